// File: rtl/de1_soc_button_pkg.sv
// Shared types and PIO register map for the DE1-SoC button host.
package de1_soc_button_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_SAMPLE,
    ST_WRITE,
    ST_SETTLE
  } state_e;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;

endpackage

// File: rtl/de1_soc_evt_fifo.sv
// Press-event FIFO with a registered head; a dropped push sets a sticky overflow flag.
module de1_soc_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             ovf_clr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic             overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, ovf_q;
  logic             full, pop_ok, push_ok, drop;

  always_comb begin
    full     = (count_q == DEPTH_C);
    pop_ok   = pop_i & valid_q;
    push_ok  = push_i & (~full | pop_ok);
    drop     = push_i & ~push_ok;
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_d   = head_q;
    // The head register is fed from the push bypass when the written slot becomes the head.
    if (count_d != '0) begin
      head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      ovf_q    <= drop | (ovf_q & ~ovf_clr_i);
    end
  end

  assign valid_o    = valid_q;
  assign head_o     = head_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/de1_soc_button_host.sv
// Avalon-MM host for the DE1-SoC button PIO: services irq, emits one event per press,
// masks held buttons and re-arms them by polling after release.
//
// state  | meaning
// INIT   | after reset, schedule the initial mask write
// IDLE   | wait for mask update, irq or poll expiry
// READ   | bus read of the PIO data register
// SAMPLE | read data valid; push event, compute new mask
// WRITE  | bus write of the PIO irq mask
// SETTLE | one cycle for irq to reflect the new mask
module de1_soc_button_host #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] INIT_MASK   = {WIDTH{1'b1}},
  parameter int               POLL_CYCLES = 50000,
  parameter int               FIFO_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic [1:0]       avm_address_o,
  output logic             avm_chipselect_o,
  output logic             avm_write_n_o,
  output logic [31:0]      avm_writedata_o,
  input  logic [31:0]      avm_readdata_i,
  input  logic             irq_i,
  input  logic             mask_wr_en_i,
  input  logic [WIDTH-1:0] mask_wr_data_i,
  output logic             evt_valid_o,
  output logic [WIDTH-1:0] evt_data_o,
  input  logic             evt_ready_i,
  output logic             overflow_o,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] eff_mask_o
);

  import de1_soc_button_pkg::*;

  localparam int PCW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_CYCLES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] user_mask_q, last_d_q, eff_mask_q, wdata_q;
  logic             mask_pend_q;
  logic [PCW-1:0]   poll_rem_q;
  logic             cs_q, write_n_q;
  logic [1:0]       addr_q;

  logic [WIDTH-1:0] umask_now, rd_bits, new_bits, rearm_mask;
  logic             pend_now, push;
  logic             unused_rd_hi;

  // A mask strobe in the deciding cycle takes effect immediately, so the write precedes any read.
  always_comb begin
    umask_now  = mask_wr_en_i ? mask_wr_data_i : user_mask_q;
    pend_now   = mask_pend_q | mask_wr_en_i;
    rd_bits    = avm_readdata_i[WIDTH-1:0];
    new_bits   = rd_bits & eff_mask_q;
    rearm_mask = umask_now & ~rd_bits;
    push       = (state_q == ST_SAMPLE) && (new_bits != '0);
  end

  assign unused_rd_hi = ^avm_readdata_i[31:WIDTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_INIT;
      user_mask_q <= INIT_MASK;
      mask_pend_q <= 1'b0;
      last_d_q    <= '0;
      eff_mask_q  <= '0;
      poll_rem_q  <= POLL_LAST;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      addr_q      <= PIO_DATA;
      wdata_q     <= '0;
    end else begin
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      mask_pend_q <= pend_now;
      if (mask_wr_en_i) user_mask_q <= mask_wr_data_i;

      unique case (state_q)
        ST_INIT: begin
          state_q     <= ST_WRITE;
          cs_q        <= 1'b1;
          write_n_q   <= 1'b0;
          addr_q      <= PIO_IRQMASK;
          wdata_q     <= umask_now;
          mask_pend_q <= 1'b0;
        end
        ST_IDLE: begin
          if (pend_now) begin
            state_q     <= ST_WRITE;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            addr_q      <= PIO_IRQMASK;
            wdata_q     <= umask_now & ~last_d_q;
            mask_pend_q <= 1'b0;
          end else if (irq_i || (poll_rem_q == '0 && eff_mask_q != user_mask_q)) begin
            state_q    <= ST_READ;
            cs_q       <= 1'b1;
            addr_q     <= PIO_DATA;
            poll_rem_q <= POLL_LAST;
          end else if (eff_mask_q != user_mask_q && poll_rem_q != '0) begin
            poll_rem_q <= poll_rem_q - PCW'(1);
          end
        end
        ST_READ: state_q <= ST_SAMPLE;
        ST_SAMPLE: begin
          last_d_q <= rd_bits;
          if (rearm_mask != eff_mask_q || pend_now) begin
            state_q     <= ST_WRITE;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            addr_q      <= PIO_IRQMASK;
            wdata_q     <= rearm_mask;
            mask_pend_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          eff_mask_q <= wdata_q;
          state_q    <= ST_SETTLE;
        end
        ST_SETTLE: state_q <= ST_IDLE;
        default:   state_q <= ST_INIT;
      endcase
    end
  end

  de1_soc_evt_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (push),
    .push_data_i(new_bits),
    .pop_i      (evt_ready_i),
    .ovf_clr_i  (ovf_clr_i),
    .valid_o    (evt_valid_o),
    .head_o     (evt_data_o),
    .overflow_o (overflow_o)
  );

  assign avm_address_o    = addr_q;
  assign avm_chipselect_o = cs_q;
  assign avm_write_n_o    = write_n_q;
  assign avm_writedata_o  = {{(32-WIDTH){1'b0}}, wdata_q};
  assign eff_mask_o       = eff_mask_q;

endmodule

// File: doc/de1_soc_button_host.md
# de1_soc_button_host

Avalon-MM host that drives the DE1-SoC 4-bit button PIO slave and turns its level interrupt into a stream of discrete press events. It sits between the PIO slave and the Plasma CPU-side event consumer. It programs the PIO interrupt mask, services `irq` by reading the data register, and queues press events in a small FIFO. Held buttons are masked off so they fire once, and periodic polling re-arms them on release.

## Interface
- `WIDTH`, 4: PIO data width (button count).
- `INIT_MASK`, 4'hF: user mask written to the PIO after reset.
- `POLL_CYCLES`, 50000: release-poll interval in clocks; 1 ms at 50 MHz.
- `FIFO_DEPTH`, 4: event FIFO entries, power of 2.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `avm_address`  out  2  PIO register address: 0 = data, 2 = irq mask.
- `avm_chipselect`  out  1  access strobe.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_writedata`  out  32  write data; bits 31:WIDTH are always 0.
- `avm_readdata`  in  32  PIO read data; fixed read latency 1, no waitrequest.
- `irq`  in  1  PIO level interrupt.
- `mask_wr_en`  in  1  one-cycle strobe that loads a new user mask.
- `mask_wr_data`  in  WIDTH  new user mask.
- `evt_valid`  out  1  FIFO head valid.
- `evt_data`  out  WIDTH  newly pressed bits (1 = pressed).
- `evt_ready`  in  1  consumer pop.
- `overflow`  out  1  sticky; set when an event is dropped on FIFO full.
- `ovf_clr`  in  1  clears `overflow`.
- `eff_mask`  out  WIDTH  mask currently programmed in the PIO.

## Operation
- PIO data bits are active-high (1 = pressed); the top level inverts the DE1-SoC KEY pins.
- Registers:
  - `user_mask`, reset value `INIT_MASK`; loaded on `mask_wr_en` in any state.
  - `mask_pend`: set on `mask_wr_en`, cleared on entry to WRITE.
  - `last_d`: last sampled data.
  - `poll_cnt`: release-poll counter.
- FSM states: INIT, IDLE, READ, SAMPLE, WRITE, SETTLE.
  - INIT → WRITE with `eff_mask_next = user_mask`.
  - IDLE decision priority:
    1. `mask_pend` → WRITE with `user_mask & ~last_d`.
    2. `irq` → READ.
    3. `poll_cnt == POLL_CYCLES-1` and `eff_mask != user_mask` → READ.
    4. Otherwise stay in IDLE.
  - READ: drive `address=0`, `chipselect=1`, `write_n=1` for one cycle → SAMPLE.
  - SAMPLE:
    - Compute `d = avm_readdata[WIDTH-1:0]`, `new = d & eff_mask`.
    - If `new != 0`, push `new`.
    - Set `last_d = d` and `m = user_mask & ~d`.
    - If `m != eff_mask` or `mask_pend` → WRITE; else → IDLE.
  - WRITE: drive `address=2`, `chipselect=1`, `write_n=0`, `writedata = eff_mask_next` for one cycle. Update `eff_mask` → SETTLE.
  - SETTLE: one idle cycle so `irq` reflects the new mask → IDLE.
- `poll_cnt` behaviour:
  - Increments only in IDLE while `eff_mask != user_mask`.
  - Clears on entry to READ.
  - Saturates at `POLL_CYCLES-1`.
- FIFO rules:
  - Push while full: drop the event and set `overflow`.
  - Push and pop in the same cycle while full: both succeed.
  - Pop on `evt_valid & evt_ready`.
  - `ovf_clr` and a set in the same cycle: set wins.
- Outside READ and WRITE, `avm_chipselect=0`, `avm_write_n=1`, and address/writedata hold their last values.

## Timing
- Reset values:
  - Bus outputs: `avm_chipselect=0`, `avm_write_n=1`, `avm_address=0`, `avm_writedata=0`.
  - Status outputs: `evt_valid=0`, `evt_data=0`, `overflow=0`, `eff_mask=0`.
  - Internal: FIFO empty, `last_d=0`, state INIT.
- First bus cycle after reset release: cycle 1 is the INIT_MASK write.
- Read path:
  - Address is driven in cycle N (READ); `avm_readdata` is sampled in cycle N+1 (SAMPLE).
  - `irq` seen in IDLE at cycle T → event visible on `evt_valid` at T+3 (READ, SAMPLE, FIFO registered).
- `evt_data` comes from a registered FIFO head and is stable while `evt_valid & ~evt_ready`.
- Reset mid-transaction: the bus strobes drop in the cycle after reset is sampled, and the FSM restarts at INIT.

## Structure
- `de1_soc_button_pkg`: FSM state enum, register address constants (`PIO_DATA=0`, `PIO_IRQMASK=2`).
- Sub-module `de1_soc_evt_fifo`: synchronous FIFO, parameterised by width and depth, with a registered head.

## Test plan
- **Reset and init:** reset, then release → cycle 1 is a write to address 2 with data 0xF; `eff_mask=0xF`.
- **Single press:**
  - Stimulus: model drives data=0x2 (irq high), hold.
  - Required: one event 0x2; mask write 0xD; no further reads until poll expiry.
  - Release, then wait `POLL_CYCLES`: read returns 0 → mask write 0xF, no event.
- **Simultaneous strobes:** `mask_wr_en` (data 0x3) in the same IDLE cycle as `irq` → the mask write (0x3) precedes the read.
- **FIFO overflow:** five press events with `evt_ready=0` → four queued, `overflow=1`; `ovf_clr` → 0.
- **Reset mid-READ:** assert `reset` during READ → `chipselect` is 0 the next cycle, the FIFO is empty, and the FSM re-enters INIT.
